tt_sweeper: RTL and testbench
=============================

TT_SWEEPER -- requirements
Module: tt_sweeper

Interface
REQ-001 Parameter SETTLE, default 1: clock cycles each input vector is held before f_in is sampled; legal range 1..15.
REQ-002 Parameter N_IN, default 7: number of function inputs; truth-table width is 2**N_IN (128).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request a sweep; sampled only in IDLE.
REQ-006 x  output  N_IN  registered input vector driven to the function-under-test; x[0] is input 0.
REQ-007 f_in  input  1  combinational output of the function-under-test.
REQ-008 busy  output  1  high while the state is DRIVE.
REQ-009 exp_tt  input  128  expected truth table, compared on completion.
REQ-010 tt  output  128  captured truth table; tt[i] = f(x=i).
REQ-011 tt_valid  output  1  captured table available.
REQ-012 tt_ready  input  1  consumer accepts tt.
REQ-013 match  output  1  (tt == exp_tt); meaningful only while tt_valid is high.

Function
REQ-014 FSM states: IDLE, DRIVE, DONE.
REQ-015 In IDLE with start=1: x<=0, hold counter<=0, tt<=0, state<=DRIVE.
REQ-016 In DRIVE, each index i is presented on x for exactly SETTLE cycles; on the last of those edges, f_in is written into tt[i].
REQ-017 After sampling, x increments by 1 with no gaps; after index 2**N_IN-1 is sampled, state<=DONE and x<=0 (no wrap into a second sweep).
REQ-018 Latency: with start sampled at edge E0, tt_valid rises at edge E0 + 2**N_IN*SETTLE (E0+128 for SETTLE=1).
REQ-019 In DONE, tt_valid=1; tt and match stay stable until an edge with tt_ready=1, which returns the state to IDLE and drops tt_valid on that edge.
REQ-020 tt keeps its last captured value in IDLE; only a new start clears it.
REQ-021 start in DRIVE or DONE is ignored (not queued).
REQ-022 tt_ready outside DONE has no effect.
REQ-023 match is registered and computed from the final tt, including the last bit; it is valid in the same cycle tt_valid rises.

Reset
REQ-024 rst_n=0 at any edge, including mid-sweep and in DONE with tt_valid high: state<=IDLE, x<=0, tt<=0, hold counter<=0, busy=0, tt_valid=0, match=0.
REQ-025 No partial table survives a reset; the first start after reset begins at index 0.

Structure
REQ-026 Shared package tt_sweep_pkg holds the state enum (IDLE/DRIVE/DONE), N_IN_DEF=7 and TT_W=2**N_IN_DEF.
REQ-027 One sub-module, tt_hold_cnt (settle down-counter with terminal pulse), is natural; index counter and capture stay in tt_sweeper.

Verification
REQ-028 Model f=x[0], SETTLE=1, tt_ready=1: start -> tt=0xAAAA...AAAA (128 bits), tt_valid at E0+128 for one cycle, busy high for 128 cycles.
REQ-029 Model f=x[6], SETTLE=3, exp_tt=0xFFFFFFFFFFFFFFFF0000000000000000 -> tt equal to it, match=1, tt_valid at E0+384.
REQ-030 Model f=1, exp_tt all-ones except bit 5 -> tt all-ones, match=0.
REQ-031 Backpressure: tt_ready low for 5 cycles in DONE, start pulsed meanwhile -> tt/match/tt_valid unchanged; release -> IDLE, no new sweep.
REQ-032 Reset mid-sweep at index 40, then start -> x restarts at 0 and the full table is correct; outputs were 0 on the reset cycle.
REQ-033 Model whose f_in depends on x only after a 1-cycle registered delay, SETTLE=2 -> correct table; SETTLE=1 -> table shifted by one index (demonstrates sample point).

Source files
------------

// File: rtl/tt_sweep_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding and
// the default function width.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } sweep_state_t;

    localparam int N_IN_DEF = 7;
    localparam int TT_W     = 2 ** N_IN_DEF;

endpackage : tt_sweep_pkg

// File: rtl/tt_hold_cnt.sv
// Settle counter: holds each input vector for SETTLE ticks and raises a
// combinational terminal pulse on the tick that ends the hold.
// A count of 0 means "fresh index"; the counter loads SETTLE-1 on the first
// tick and the hold ends on the tick where the count is 1.
module tt_hold_cnt #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic tick,
    output logic term
);

    logic [3:0] cnt;

    assign term = tick && ((SETTLE == 1) || (cnt == 4'd1));

    // Down-count through the hold window, returning to 0 after each terminal tick.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (clr) begin
            cnt <= 4'd0;
        end else if (tick) begin
            if (term) begin
                cnt <= 4'd0;
            end else if (cnt == 4'd0) begin
                cnt <= 4'(SETTLE - 1);
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

endmodule : tt_hold_cnt

// File: rtl/tt_sweeper.sv
// Exhaustive truth-table capture: drives every input vector of an N_IN-input
// combinational function, samples its output after SETTLE cycles, and hands
// the captured table (plus a compare against an expected table) to a consumer.
module tt_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE = 1,
    parameter int N_IN   = N_IN_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [N_IN-1:0]      x,
    input  logic                 f_in,
    output logic                 busy,
    input  logic [2**N_IN-1:0]   exp_tt,
    output logic [2**N_IN-1:0]   tt,
    output logic                 tt_valid,
    input  logic                 tt_ready,
    output logic                 match
);

    localparam logic [N_IN-1:0] X_MAX = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] X_ONE = N_IN'(1);

    sweep_state_t          state, state_nxt;
    logic [N_IN-1:0]       x_nxt;
    logic [2**N_IN-1:0]    tt_nxt;
    logic [2**N_IN-1:0]    tt_cap;
    logic                  match_nxt;
    logic                  cnt_clr;
    logic                  cnt_tick;
    logic                  cnt_term;

    tt_hold_cnt #(
        .SETTLE (SETTLE)
    ) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .tick  (cnt_tick),
        .term  (cnt_term)
    );

    assign busy     = (state == DRIVE);
    assign tt_valid = (state == DONE);

    // State, input vector, captured table and compare result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            x     <= '0;
            tt    <= '0;
            match <= 1'b0;
        end else begin
            state <= state_nxt;
            x     <= x_nxt;
            tt    <= tt_nxt;
            match <= match_nxt;
        end
    end

    // Next-state logic: start a sweep, step through indices, wait for the consumer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_nxt = state;
        x_nxt     = x;
        tt_nxt    = tt;
        match_nxt = match;
        cnt_clr   = 1'b0;
        cnt_tick  = 1'b0;
        // Table with the current sample folded in, so the final compare sees
        // the last bit in the same edge it is captured.
        tt_cap    = tt;
        tt_cap[x] = f_in;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DRIVE;
                    x_nxt     = '0;
                    tt_nxt    = '0;
                    match_nxt = 1'b0;
                    cnt_clr   = 1'b1;
                end
            end
            DRIVE: begin
                cnt_tick = 1'b1;
                if (cnt_term) begin
                    tt_nxt = tt_cap;
                    if (x == X_MAX) begin
                        state_nxt = DONE;
                        x_nxt     = '0;
                        match_nxt = (tt_cap == exp_tt);
                    end else begin
                        x_nxt = x + X_ONE;
                    end
                end
            end
            DONE: begin
                if (tt_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule : tt_sweeper

// File: tb/tb_tt_sweeper.sv
// Directed bench for tt_sweeper. Three instances differ only in SETTLE
// (index 0: SETTLE=1, index 1: SETTLE=2, index 2: SETTLE=3); each has its own
// function-under-test model selected by mode_a.
`timescale 1ns/1ps
module tb_tt_sweeper;

    localparam logic [127:0] TT_ALT   = 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA;
    localparam logic [127:0] TT_SHIFT = 128'h55555555555555555555555555555554;
    localparam logic [127:0] TT_HIGH  = 128'hFFFFFFFFFFFFFFFF0000000000000000;
    localparam logic [127:0] TT_ONES  = {128{1'b1}};
    localparam logic [127:0] TT_NOT5  = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFDF;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_a  [3];
    logic [6:0]   x_a      [3];
    logic [6:0]   xd_a     [3];
    logic         f_a      [3];
    logic         busy_a   [3];
    logic [127:0] exp_a    [3];
    logic [127:0] tt_a     [3];
    logic         valid_a  [3];
    logic         ready_a  [3];
    logic         match_a  [3];
    logic [1:0]   mode_a   [3];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    tt_sweeper #(.SETTLE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_a[0]), .x(x_a[0]), .f_in(f_a[0]),
        .busy(busy_a[0]), .exp_tt(exp_a[0]), .tt(tt_a[0]), .tt_valid(valid_a[0]),
        .tt_ready(ready_a[0]), .match(match_a[0])
    );
    tt_sweeper #(.SETTLE(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_a[1]), .x(x_a[1]), .f_in(f_a[1]),
        .busy(busy_a[1]), .exp_tt(exp_a[1]), .tt(tt_a[1]), .tt_valid(valid_a[1]),
        .tt_ready(ready_a[1]), .match(match_a[1])
    );
    tt_sweeper #(.SETTLE(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_a[2]), .x(x_a[2]), .f_in(f_a[2]),
        .busy(busy_a[2]), .exp_tt(exp_a[2]), .tt(tt_a[2]), .tt_valid(valid_a[2]),
        .tt_ready(ready_a[2]), .match(match_a[2])
    );

    // Function-under-test models: 0 -> x[0], 1 -> x[6], 2 -> constant 1,
    // 3 -> x[0] seen through a one-cycle register.
    function automatic logic fmodel(input logic [1:0] m, input logic [6:0] xv, input logic [6:0] xdv);
        case (m)
            2'd0:    return xv[0];
            2'd1:    return xv[6];
            2'd2:    return 1'b1;
            default: return xdv[0];
        endcase
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) xd_a[i] <= x_a[i];
    end

    always_comb begin
        for (int i = 0; i < 3; i++) f_a[i] = fmodel(mode_a[i], x_a[i], xd_a[i]);
    end

    // Pulse start on instance d, then count edges until tt_valid (bounded).
    // lat = edges after the start edge; bcnt = samples with busy high;
    // xprobe = x observed lat==probe edges after the start edge.
    task automatic run_sweep(input int d, input int probe, output int lat, output int bcnt,
                             output logic [6:0] xprobe);
        lat = 0; bcnt = 0; xprobe = 7'h7f;
        start_a[d] = 1'b1;
        @(posedge clk); #1;
        start_a[d] = 1'b0;
        while (valid_a[d] !== 1'b1 && lat < 2000) begin
            if (busy_a[d] === 1'b1) bcnt++;
            if (lat == probe) xprobe = x_a[d];
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_a[i] = 1'b0; ready_a[i] = 1'b1; mode_a[i] = 2'd0; exp_a[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            total++; if (x_a[i] !== 7'd0) $display("FAIL reset_x[%0d]: got %h expected 0", i, x_a[i]); else passed++;
            total++; if (tt_a[i] !== '0) $display("FAIL reset_tt[%0d]: got %h expected 0", i, tt_a[i]); else passed++;
            total++; if ({busy_a[i], valid_a[i], match_a[i]} !== 3'b000)
                $display("FAIL reset_flags[%0d]: got busy/valid/match=%b%b%b expected 000", i, busy_a[i], valid_a[i], match_a[i]);
            else passed++;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_sweep_x0();
        int lat, bcnt;
        logic [6:0] xp;
        mode_a[0] = 2'd0; exp_a[0] = TT_ALT; ready_a[0] = 1'b1;
        run_sweep(0, 40, lat, bcnt, xp);
        total++; if (xp !== 7'd40) $display("FAIL x0_index40: got %0d expected 40", xp); else passed++;
        total++; if (lat !== 128) $display("FAIL x0_latency: got %0d expected 128", lat); else passed++;
        total++; if (bcnt !== 128) $display("FAIL x0_busy_cycles: got %0d expected 128", bcnt); else passed++;
        total++; if (tt_a[0] !== TT_ALT) $display("FAIL x0_tt: got %h expected %h", tt_a[0], TT_ALT); else passed++;
        total++; if (match_a[0] !== 1'b1) $display("FAIL x0_match: got %b expected 1", match_a[0]); else passed++;
        total++; if (x_a[0] !== 7'd0) $display("FAIL x0_x_done: got %0d expected 0", x_a[0]); else passed++;
        total++; if (busy_a[0] !== 1'b0) $display("FAIL x0_busy_done: got %b expected 0", busy_a[0]); else passed++;
        @(posedge clk); #1;
        total++; if (valid_a[0] !== 1'b0) $display("FAIL x0_valid_one_cycle: got %b expected 0", valid_a[0]); else passed++;
        total++; if (tt_a[0] !== TT_ALT) $display("FAIL x0_tt_kept_idle: got %h expected %h", tt_a[0], TT_ALT); else passed++;
    endtask

    task automatic test_settle3();
        int lat, bcnt;
        logic [6:0] xp;
        mode_a[2] = 2'd1; exp_a[2] = TT_HIGH; ready_a[2] = 1'b1;
        run_sweep(2, 3, lat, bcnt, xp);
        total++; if (xp !== 7'd1) $display("FAIL s3_x_after_3: got %0d expected 1", xp); else passed++;
        total++; if (lat !== 384) $display("FAIL s3_latency: got %0d expected 384", lat); else passed++;
        total++; if (bcnt !== 384) $display("FAIL s3_busy_cycles: got %0d expected 384", bcnt); else passed++;
        total++; if (tt_a[2] !== TT_HIGH) $display("FAIL s3_tt: got %h expected %h", tt_a[2], TT_HIGH); else passed++;
        total++; if (match_a[2] !== 1'b1) $display("FAIL s3_match: got %b expected 1", match_a[2]); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_mismatch_backpressure();
        int lat, bcnt;
        logic [6:0] xp;
        mode_a[0] = 2'd2; exp_a[0] = TT_NOT5; ready_a[0] = 1'b0;
        run_sweep(0, 0, lat, bcnt, xp);
        total++; if (lat !== 128) $display("FAIL bp_latency: got %0d expected 128", lat); else passed++;
        total++; if (tt_a[0] !== TT_ONES) $display("FAIL bp_tt: got %h expected %h", tt_a[0], TT_ONES); else passed++;
        total++; if (match_a[0] !== 1'b0) $display("FAIL bp_match: got %b expected 0", match_a[0]); else passed++;
        for (int j = 0; j < 5; j++) begin
            start_a[0] = (j == 2);
            @(posedge clk); #1;
            total++; if ({valid_a[0], match_a[0], busy_a[0]} !== 3'b100)
                $display("FAIL bp_hold[%0d]: got valid/match/busy=%b%b%b expected 100", j, valid_a[0], match_a[0], busy_a[0]);
            else passed++;
            total++; if (tt_a[0] !== TT_ONES) $display("FAIL bp_tt_hold[%0d]: got %h expected %h", j, tt_a[0], TT_ONES); else passed++;
        end
        start_a[0] = 1'b0;
        ready_a[0] = 1'b1;
        @(posedge clk); #1;
        total++; if (valid_a[0] !== 1'b0) $display("FAIL bp_release_valid: got %b expected 0", valid_a[0]); else passed++;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy_a[0] !== 1'b0) $display("FAIL bp_no_queued_start: got busy %b expected 0", busy_a[0]); else passed++;
    endtask

    task automatic test_reset_mid();
        int lat, bcnt;
        logic [6:0] xp;
        mode_a[0] = 2'd0; exp_a[0] = TT_ALT; ready_a[0] = 1'b1;
        start_a[0] = 1'b1;
        @(posedge clk); #1;
        start_a[0] = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        total++; if (x_a[0] !== 7'd40) $display("FAIL rm_index: got %0d expected 40", x_a[0]); else passed++;
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++; if (x_a[0] !== 7'd0) $display("FAIL rm_x: got %0d expected 0", x_a[0]); else passed++;
        total++; if (tt_a[0] !== '0) $display("FAIL rm_tt: got %h expected 0", tt_a[0]); else passed++;
        total++; if ({busy_a[0], valid_a[0], match_a[0]} !== 3'b000)
            $display("FAIL rm_flags: got busy/valid/match=%b%b%b expected 000", busy_a[0], valid_a[0], match_a[0]);
        else passed++;
        rst_n = 1'b1;
        mode_a[0] = 2'd1; exp_a[0] = TT_HIGH;
        @(posedge clk); #1;
        run_sweep(0, 0, lat, bcnt, xp);
        total++; if (xp !== 7'd0) $display("FAIL rm_restart_x: got %0d expected 0", xp); else passed++;
        total++; if (lat !== 128) $display("FAIL rm_latency: got %0d expected 128", lat); else passed++;
        total++; if (tt_a[0] !== TT_HIGH) $display("FAIL rm_tt_full: got %h expected %h", tt_a[0], TT_HIGH); else passed++;
        total++; if (match_a[0] !== 1'b1) $display("FAIL rm_match: got %b expected 1", match_a[0]); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_delayed_function();
        int lat, bcnt;
        logic [6:0] xp;
        // SETTLE=1 samples one index too early: tt[i] = (i-1)[0], tt[0] = 0.
        mode_a[0] = 2'd3; exp_a[0] = TT_SHIFT; ready_a[0] = 1'b1;
        run_sweep(0, 0, lat, bcnt, xp);
        total++; if (tt_a[0] !== TT_SHIFT) $display("FAIL dly_s1_tt: got %h expected %h", tt_a[0], TT_SHIFT); else passed++;
        total++; if (match_a[0] !== 1'b1) $display("FAIL dly_s1_match: got %b expected 1", match_a[0]); else passed++;
        @(posedge clk); #1;
        // SETTLE=2 waits out the register and captures the true table.
        mode_a[1] = 2'd3; exp_a[1] = TT_ALT; ready_a[1] = 1'b0;
        run_sweep(1, 0, lat, bcnt, xp);
        total++; if (lat !== 256) $display("FAIL dly_s2_latency: got %0d expected 256", lat); else passed++;
        total++; if (tt_a[1] !== TT_ALT) $display("FAIL dly_s2_tt: got %h expected %h", tt_a[1], TT_ALT); else passed++;
        total++; if (match_a[1] !== 1'b1) $display("FAIL dly_s2_match: got %b expected 1", match_a[1]); else passed++;
        // Reset while the table is being presented.
        repeat (2) @(posedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++; if ({valid_a[1], match_a[1]} !== 2'b00)
            $display("FAIL dly_reset_done: got valid/match=%b%b expected 00", valid_a[1], match_a[1]);
        else passed++;
        total++; if (tt_a[1] !== '0) $display("FAIL dly_reset_tt: got %h expected 0", tt_a[1]); else passed++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_sweep_x0();
        test_settle3();
        test_mismatch_backpressure();
        test_reset_mid();
        test_delayed_function();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_tt_sweeper
